// File: rtl/reg_writeback_unit_pkg.sv
// Shared encodings for the writeback stage: result sources, load sizes,
// FSM states and the hard-wired zero register.
package wb_pkg;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    WB_IDLE     = 1'b0,
    WB_MEM_WAIT = 1'b1
  } wb_state_e;

  // A load is misaligned when its byte offset does not fit its size;
  // the reserved size encoding is always treated as misaligned.
  function automatic logic load_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
    logic mis;
    case (size)
      LS_BYTE: mis = 1'b0;
      LS_HALF: mis = offset[0];
      LS_WORD: mis = (offset != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/reg_writeback_unit_load_align.sv
// Little-endian lane select and sign/zero extension of a load word.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/half lane and extend it to 32 bits.
  always_comb begin
    case (offset)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      2'b11:   byte_lane = rdata[31:24];
      default: byte_lane = 8'h00;
    endcase
    if (offset[1]) begin
      half_lane = rdata[31:16];
    end else begin
      half_lane = rdata[15:0];
    end
    case (size)
      LS_BYTE: data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      LS_HALF: data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
      LS_WORD: data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback stage: owns the register-file write port, sources results from
// ALU, link address or a data-memory load, and exposes the in-flight dest.
module reg_writeback_unit
  import wb_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wr_req,
  input  logic [4:0]  in_dest,
  input  logic [1:0]  in_src_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_link_addr,
  input  logic [1:0]  in_load_size,
  input  logic        in_load_unsigned,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_write_en,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        pending_valid,
  output logic [4:0]  pending_dest,
  output logic        err
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  wb_state_e   state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        pend_v_q, pend_v_d;
  logic [4:0]  pend_dest_q, pend_dest_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  ld_dest_q, ld_dest_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_uns_q, ld_uns_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        ld_wr_q, ld_wr_d;

  logic        accept;
  logic        in_will_write;
  logic        in_misaligned;
  logic        timeout;
  logic [31:0] ld_data;

  load_align u_load_align (
    .rdata       (mem_rdata),
    .offset      (ld_off_q),
    .size        (ld_size_q),
    .is_unsigned (ld_uns_q),
    .data        (ld_data)
  );

  assign accept        = in_valid & in_ready;
  assign in_will_write = in_wr_req & (in_dest != REG_ZERO);
  assign in_misaligned = load_misaligned(in_load_size, in_alu_result[1:0]);
  assign timeout       = (cnt_q == TO_LAST);

  // FSM state register; reset aborts any outstanding load immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only an aligned load leaves IDLE; ack or timeout returns.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE: begin
        if (accept && (in_src_sel == SRC_LOAD) && !in_misaligned) begin
          state_d = WB_MEM_WAIT;
        end else begin
          state_d = WB_IDLE;
        end
      end
      WB_MEM_WAIT: begin
        if (mem_ack || timeout) begin
          state_d = WB_IDLE;
        end else begin
          state_d = WB_MEM_WAIT;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // FSM output: execute may hand over an instruction only while idle.
  always_comb begin
    if (state_q == WB_IDLE) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
  end

  // Datapath next values: write strobe, memory request, hazard tracking.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    pend_v_d    = 1'b0;
    pend_dest_d = pend_dest_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    ld_dest_d   = ld_dest_q;
    ld_size_d   = ld_size_q;
    ld_uns_d    = ld_uns_q;
    ld_off_d    = ld_off_q;
    ld_wr_d     = ld_wr_q;
    case (state_q)
      WB_IDLE: begin
        if (accept) begin
          case (in_src_sel)
            SRC_ALU, SRC_LINK: begin
              rf_we_d     = in_will_write;
              rf_waddr_d  = in_dest;
              rf_wdata_d  = (in_src_sel == SRC_LINK) ? in_link_addr : in_alu_result;
              pend_v_d    = in_will_write;
              pend_dest_d = in_dest;
            end
            SRC_LOAD: begin
              if (in_misaligned) begin
                err_d = 1'b1;
              end else begin
                mem_req_d   = 1'b1;
                mem_addr_d  = {in_alu_result[31:2], 2'b00};
                cnt_d       = 8'd0;
                ld_dest_d   = in_dest;
                ld_size_d   = in_load_size;
                ld_uns_d    = in_load_unsigned;
                ld_off_d    = in_alu_result[1:0];
                ld_wr_d     = in_will_write;
                pend_v_d    = in_will_write;
                pend_dest_d = in_dest;
              end
            end
            default: begin
              rf_we_d = 1'b0;
            end
          endcase
        end else begin
          rf_we_d = 1'b0;
        end
      end
      WB_MEM_WAIT: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          rf_we_d    = ld_wr_q;
          rf_waddr_d = ld_dest_q;
          rf_wdata_d = ld_data;
          pend_v_d   = ld_wr_q;
        end else if (timeout) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          pend_v_d  = 1'b0;
        end else begin
          pend_v_d = pend_v_q;
          cnt_d    = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; every output is driven straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'd0;
      pend_v_q    <= 1'b0;
      pend_dest_q <= 5'd0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
      ld_dest_q   <= 5'd0;
      ld_size_q   <= 2'b00;
      ld_uns_q    <= 1'b0;
      ld_off_q    <= 2'b00;
      ld_wr_q     <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      pend_v_q    <= pend_v_d;
      pend_dest_q <= pend_dest_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      ld_dest_q   <= ld_dest_d;
      ld_size_q   <= ld_size_d;
      ld_uns_q    <= ld_uns_d;
      ld_off_q    <= ld_off_d;
      ld_wr_q     <= ld_wr_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign rf_write_en   = rf_we_q;
  assign rf_write_addr = rf_waddr_q;
  assign rf_write_data = rf_wdata_q;
  assign pending_valid = pend_v_q;
  assign pending_dest  = pend_dest_q;
  assign err           = err_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Scoreboard bench for reg_writeback_unit: the driver pushes expected
// register writes and error pulses, an independent monitor pops and compares.
module tb_reg_writeback_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_wr_req, in_load_unsigned;
  logic [4:0]  in_dest;
  logic [1:0]  in_src_sel, in_load_size;
  logic [31:0] in_alu_result, in_link_addr;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        rf_write_en, pending_valid, err;
  logic [4:0]  rf_write_addr, pending_dest;
  logic [31:0] rf_write_data;

  always #5 clk = ~clk;

  reg_writeback_unit #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wr_req(in_wr_req),
    .in_dest(in_dest), .in_src_sel(in_src_sel), .in_alu_result(in_alu_result),
    .in_link_addr(in_link_addr), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .pending_valid(pending_valid), .pending_dest(pending_dest), .err(err)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t wq[$];
  bit  eq[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference load result from the little-endian byte rules.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input int off,
                                             input int size, input bit uns);
    logic [31:0] v;
    if (size == 0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Monitor: every write strobe and error pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_write_en) begin
        if (wq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0d data %h, none expected", rf_write_addr, rf_write_data);
        end else begin
          mon_e = wq.pop_front();
          chk("wr_addr", {27'd0, rf_write_addr}, {27'd0, mon_e.a});
          chk("wr_data", rf_write_data, mon_e.d);
        end
      end
      if (err) begin
        tests++;
        if (eq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_err: err=1, no error expected (t=%0t)", $time);
        end else begin
          void'(eq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_simple(input logic [4:0] dest, input logic [1:0] src, input bit wr,
                             input logic [31:0] alu, input logic [31:0] link);
    bit will;
    will = wr && (dest != 5'd0) && (src == 2'b00 || src == 2'b10);
    in_valid = 1'b1; in_wr_req = wr; in_dest = dest; in_src_sel = src;
    in_alu_result = alu; in_link_addr = link;
    in_load_size = 2'($urandom_range(0, 3)); in_load_unsigned = 1'($urandom_range(0, 1));
    if (will) wq.push_back('{a: dest, d: (src == 2'b10) ? link : alu});
    tick();
    in_valid = 1'b0;
    chk("simple_ready", {31'd0, in_ready}, 32'd1);
    chk("simple_pend_v", {31'd0, pending_valid}, {31'd0, will});
    if (will) chk("simple_pend_dest", {27'd0, pending_dest}, {27'd0, dest});
  endtask

  task automatic do_load(input logic [4:0] dest, input bit wr, input logic [31:0] addr,
                         input logic [1:0] size, input bit uns, input logic [31:0] rdata,
                         input int ack_delay);
    int  off, sz, last;
    bit  mis, will, acked;
    off  = int'(addr[1:0]);
    sz   = int'(size);
    mis  = (sz == 3) || (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0);
    will = wr && (dest != 5'd0);
    in_valid = 1'b1; in_wr_req = wr; in_dest = dest; in_src_sel = 2'b01;
    in_alu_result = addr; in_link_addr = $urandom; in_load_size = size; in_load_unsigned = uns;
    if (mis) eq.push_back(1'b1);
    tick();
    in_valid = 1'b0;
    if (mis) begin
      chk("mis_no_req", {31'd0, mem_req}, 32'd0);
      chk("mis_ready", {31'd0, in_ready}, 32'd1);
      chk("mis_pend", {31'd0, pending_valid}, 32'd0);
    end else begin
      acked = (ack_delay < T);
      last  = acked ? ack_delay : T - 1;
      if (acked && will) wq.push_back('{a: dest, d: model_load(rdata, off, sz, uns)});
      if (!acked) eq.push_back(1'b1);
      chk("ld_pend_start", {31'd0, pending_valid}, {31'd0, will});
      for (int k = 0; k <= last; k++) begin
        chk("mem_req_hold", {31'd0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("ready_low", {31'd0, in_ready}, 32'd0);
        mem_rdata = (acked && k == last) ? rdata : $urandom;
        mem_ack   = acked && (k == last);
        tick();
        mem_ack = 1'b0;
      end
      chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
      chk("ready_back", {31'd0, in_ready}, 32'd1);
      chk("ld_pend_end", {31'd0, pending_valid}, {31'd0, acked && will});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_wr_req = 1'b0; in_dest = 5'd0; in_src_sel = 2'b00;
    in_alu_result = 32'd0; in_link_addr = 32'd0; in_load_size = 2'b00;
    in_load_unsigned = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #3;
    chk("rst_we", {31'd0, rf_write_en}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_pend", {31'd0, pending_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", rf_write_data, 32'd0);
    chk("rst_waddr", {27'd0, rf_write_addr}, 32'd0);
    chk("rst_pdest", {27'd0, pending_dest}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Back-to-back ALU writes.
    send_simple(5'd3, 2'b00, 1'b1, 32'h1234_5678, 32'd0);
    send_simple(5'd4, 2'b00, 1'b1, 32'hCAFE_BABE, 32'd0);
    // Signed then unsigned byte load from lane 3, ack in third wait cycle.
    do_load(5'd5, 1'b1, 32'h0000_0103, 2'b00, 1'b0, 32'h80FF_0011, 2);
    do_load(5'd6, 1'b1, 32'h0000_0103, 2'b00, 1'b1, 32'h80FF_0011, 2);
    // Misaligned half load.
    do_load(5'd7, 1'b1, 32'h0000_0201, 2'b01, 1'b0, 32'h1111_2222, 0);
    // LINK to register 0: accepted, no write.
    send_simple(5'd0, 2'b10, 1'b1, 32'd0, 32'h0000_0044);
    // Timeout with no ack, then a stray ack while idle must be ignored.
    do_load(5'd8, 1'b1, 32'h0000_0400, 2'b10, 1'b0, 32'hDEAD_BEEF, 99);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    // Ack on the timeout edge wins.
    do_load(5'd9, 1'b1, 32'h0000_0404, 2'b10, 1'b0, 32'h1357_9BDF, T - 1);

    // Reset in the second MEM_WAIT cycle discards the load.
    in_valid = 1'b1; in_wr_req = 1'b1; in_dest = 5'd10; in_src_sel = 2'b01;
    in_alu_result = 32'h0000_0800; in_load_size = 2'b10; in_load_unsigned = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("rstmid_req_on", {31'd0, mem_req}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rstmid_ready", {31'd0, in_ready}, 32'd1);
    chk("rstmid_pend", {31'd0, pending_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("rstmid_no_req", {31'd0, mem_req}, 32'd0);
    send_simple(5'd11, 2'b00, 1'b1, 32'h0BAD_F00D, 32'd0);

    // Randomized mix against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] src;
      logic [4:0] dest;
      bit         wr;
      src  = 2'($urandom_range(0, 3));
      dest = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wr   = ($urandom_range(0, 5) != 0);
      if (src == 2'b01) begin
        do_load(dest, wr, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom_range(0, 5));
      end else begin
        send_simple(dest, src, wr, $urandom, $urandom);
      end
    end

    tick(); tick(); tick();
    chk("wq_drained", wq.size(), 32'd0);
    chk("eq_drained", eq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_writeback_unit.md
# reg_writeback_unit

Writeback stage that owns the write port of the 32×32 register file. It accepts completed instructions from execute, sources the result from the ALU, the link address, or a data-memory load via a req/ack handshake, and then drives the register file's `write_en`/`write_addr`/`write_data`. It also exposes the in-flight destination so decode can stall on read-after-write hazards.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum number of cycles in `MEM_WAIT` before the load is aborted. Must be at least 1.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: execute presents an instruction.
- `in_ready` out 1: the unit can accept an instruction. Equals `state==IDLE`.
- `in_wr_req` in 1: the instruction writes a register.
- `in_dest` in 5: destination register.
- `in_src_sel` in 2: result source. 00 = ALU, 01 = LOAD, 10 = LINK, 11 = reserved (treated as no write).
- `in_alu_result` in 32: ALU result. For loads this is the byte address.
- `in_link_addr` in 32: PC+4 for link instructions.
- `in_load_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = reserved (misaligned error).
- `in_load_unsigned` in 1: zero-extend when 1, sign-extend when 0.
- `mem_req` out 1: load request to data memory.
- `mem_addr` out 32: word-aligned load address, `{addr[31:2],2'b00}`.
- `mem_ack` in 1: memory returns data this cycle.
- `mem_rdata` in 32: memory read data.
- `rf_write_en` out 1: register-file write strobe.
- `rf_write_addr` out 5: register-file write address.
- `rf_write_data` out 32: register-file write data.
- `pending_valid` out 1: a register write is in flight.
- `pending_dest` out 5: destination of the in-flight write.
- `err` out 1: one-cycle pulse on a misaligned load or a timeout.

## Operation
State machine has two states, `IDLE` and `MEM_WAIT`.

IDLE:
- An instruction is accepted when `in_valid && in_ready`.
- ALU or LINK source: register `rf_write_*` for the next cycle. The state stays `IDLE`.
- LOAD source, aligned: latch dest, size, unsigned flag and `addr[1:0]`. Assert `mem_req` and `mem_addr`, then go to `MEM_WAIT`.
- LOAD source, misaligned (half with `addr[0]=1`, word with `addr[1:0]!=0`, or size 11): no request and no write. Pulse `err` next cycle. The state stays `IDLE`.

MEM_WAIT:
- `mem_req` and `mem_addr` are held stable until `mem_ack` is sampled high.
- On ack: extract and extend the data, issue the register write next cycle, drop `mem_req`, go to `IDLE`.
- On timeout: drop `mem_req`, pulse `err`, no write, go to `IDLE`.

Load extraction (little-endian):
- Byte: lane `addr[1:0]`.
- Half: lane `addr[1]`.
- Word: the full 32 bits.
- Extension follows `in_load_unsigned`.

Other rules:
- Register 0 is never written. `rf_write_en` stays 0 when dest is 0, but the handshake completes normally.
- `in_wr_req=0` or `src_sel=11`: the instruction is accepted and no write occurs. A load with `in_wr_req=0` still performs the memory access.
- `mem_ack` is ignored outside `MEM_WAIT`.
- `pending_valid`/`pending_dest` are high from the accept cycle's next edge until the cycle `rf_write_en` is asserted, inclusive.

## Timing
- Reset values: state `IDLE`; `mem_req`, `rf_write_en`, `pending_valid` and `err` are 0; all address, data and dest outputs are 0; the timeout counter is 0. `in_ready` is 1.
- ALU/LINK latency: accepted at edge N, `rf_write_en` high for exactly the cycle after N. Throughput is one instruction per cycle.
- Load latency: accepted at edge N, `mem_req` high from N+1. An ack sampled at edge M gives `rf_write_en` in cycle M+1 and `mem_req` low in cycle M+1. Minimum total is 2 cycles to the write.
- `in_ready` is 0 throughout `MEM_WAIT`. The next instruction is accepted on the same edge the load write is registered.
- Timeout counter:
  - Cleared on entry to `MEM_WAIT`, 8 bits wide, saturating.
  - When the counter equals `MEM_TIMEOUT-1` with no ack, abort on that edge.
  - An ack on the same edge as the timeout wins: the write happens and `err` stays 0.
- Reset asserted mid-`MEM_WAIT` returns to `IDLE` immediately (asynchronously), drops `mem_req`, and discards the load without a write.

## Structure
- Shared package `wb_pkg` holds:
  - The `src_sel` encodings (`SRC_ALU`, `SRC_LOAD`, `SRC_LINK`).
  - The load-size encodings (`LS_BYTE`, `LS_HALF`, `LS_WORD`).
  - The state enum (`WB_IDLE`, `WB_MEM_WAIT`).
  - The `REG_ZERO=5'd0` constant.
- Sub-module `load_align`: a combinational lane select plus sign/zero extension. Inputs are `rdata`, `offset[1:0]`, `size` and `unsigned`; output is the 32-bit data.

## Test plan
- ALU ops back-to-back: dest 3 = 0x12345678, then dest 4 = 0xCAFEBABE on consecutive cycles. Expect two consecutive `rf_write_en` pulses with matching addr/data and `in_ready` held at 1.
- Signed byte load: addr 0x103, `mem_rdata` 0x80FF0011, ack after 3 cycles. Expect `mem_addr` 0x100 held 3 cycles, then a write of 0xFFFFFF80.
  - Repeat unsigned: expect 0x00000080.
- Misaligned half: addr 0x201. Expect no `mem_req`, an `err` pulse of 1 cycle, no write, and `in_ready` back at 1 the next cycle.
- Dest 0 LINK with `in_link_addr` 0x44. Expect `rf_write_en` to stay 0 and the instruction to be accepted.
- `MEM_TIMEOUT=4` with no ack. Expect `mem_req` high for 4 cycles, then an `err` pulse and no write.
  - Then ack and timeout on the same edge: expect the write to occur and `err` to stay 0.
- `rst_n` asserted in cycle 2 of `MEM_WAIT`. Expect `mem_req` to drop immediately, no write, and a later ack to be ignored.
